// File: rtl/magnitude_decoder_pkg.sv
// Shared types and sizing helpers for the bit-serial two's-complement to
// sign-magnitude decoder.
package magnitude_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bit counter width: must hold WIDTH-1 so the terminal compare is reached.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/magnitude_decoder_if.sv
// Valid/ready handshake bundle between the adder, the decoder and the
// result formatter.
interface magnitude_decoder_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             NEG;

   modport master (
      output in_valid, A, out_ready,
      input  in_ready, out_valid, S, NEG
   );

   modport slave (
      input  in_valid, A, out_ready,
      output in_ready, out_valid, S, NEG
   );
endinterface

// File: rtl/magnitude_decoder_serial_negate_cell.sv
// One-bit serial two's-complement negate step: pass bits up to and including
// the first 1, invert every later bit when the word is negative.
module serial_negate_cell (
   input  logic b,
   input  logic neg,
   input  logic seen,
   output logic o,
   output logic seen_next
);

   assign o         = (neg && seen) ? ~b : b;
   assign seen_next = seen | b;

endmodule

// File: rtl/magnitude_decoder.sv
// LSB-first serial decoder: returns |A| and the sign of a WIDTH-bit
// two's-complement word with a fixed latency of WIDTH shift cycles.
module magnitude_decoder
   import magnitude_decoder_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic               clk,
   input  logic               rst,
   magnitude_decoder_if.slave bus
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] sr_r;
   logic             neg_r;
   logic             seen_r;
   logic [CW-1:0]    cnt_r;
   logic             accept_s;
   logic             shift_s;
   logic             o_s;
   logic             seen_next_s;

   serial_negate_cell u_cell (
      .b         (sr_r[0]),
      .neg       (neg_r),
      .seen      (seen_r),
      .o         (o_s),
      .seen_next (seen_next_s)
   );

   // Next-state decode and per-cycle enables for the datapath registers.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      shift_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               accept_s = 1'b1;
               state_s  = ST_SHIFT;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_s = 1'b1;
            if (cnt_r == CNT_LAST) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register plus shift register, sign, first-one flag and bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         sr_r    <= '0;
         neg_r   <= 1'b0;
         seen_r  <= 1'b0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            sr_r   <= bus.A;
            neg_r  <= bus.A[WIDTH-1];
            seen_r <= 1'b0;
            cnt_r  <= '0;
         end else if (shift_s) begin
            sr_r   <= {o_s, sr_r[WIDTH-1:1]};
            seen_r <= seen_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
         end else begin
            sr_r   <= sr_r;
            seen_r <= seen_r;
            cnt_r  <= cnt_r;
         end
      end
   end

   // Outputs come straight from registers or the state decode; in_ready is
   // also held low while reset is asserted.
   assign bus.in_ready  = (state_r == ST_IDLE) && !rst;
   assign bus.out_valid = (state_r == ST_DONE);
   assign bus.S         = sr_r;
   assign bus.NEG       = neg_r;

endmodule

// File: tb/tb_magnitude_decoder.sv
// Scoreboard bench: directed WIDTH=4 cases plus a shuffled WIDTH=8 sweep with
// random output stalls, checked against an arithmetic |A| model.
module tb_magnitude_decoder;

   typedef struct {
      logic [7:0] s;
      logic       neg;
   } exp_t;

   logic clk = 1'b0;
   logic rst4;
   logic rst8;
   int   cyc     = 0;
   int   n_pass  = 0;
   int   n_total = 0;

   exp_t q4[$];
   exp_t q8[$];
   int   acc4[$];
   int   acc8[$];

   logic [3:0] dir4 [6];

   magnitude_decoder_if #(.WIDTH(4)) bus4 ();
   magnitude_decoder_if #(.WIDTH(8)) bus8 ();

   magnitude_decoder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
   magnitude_decoder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference: interpret a as a w-bit signed value and take its absolute value.
   function automatic exp_t model(input int w, input int a);
      exp_t e;
      int   v;
      v = a;
      if (a >= (1 << (w - 1))) v = a - (1 << w);
      e.neg = (v < 0);
      e.s   = 8'((v < 0) ? -v : v);
      return e;
   endfunction

   // Monitor for the 4-bit instance.
   initial begin
      exp_t cur;
      logic prev;
      prev = 1'b0;
      cur  = '{s: 8'd0, neg: 1'b0};
      forever begin
         @(negedge clk);
         if (rst4) begin
            prev = 1'b0;
         end else begin
            if (bus4.in_valid && bus4.in_ready) acc4.push_back(cyc + 1);
            if (bus4.out_valid && !prev) begin
               if (q4.size() == 0) begin
                  chk("w4_unexpected_result", 32'd1, 32'd0);
               end else begin
                  cur = q4.pop_front();
                  chk("w4_S", 32'(bus4.S), 32'(cur.s));
                  chk("w4_NEG", 32'(bus4.NEG), 32'(cur.neg));
                  if (acc4.size() != 0) chk("w4_latency", 32'(cyc - acc4.pop_front()), 32'd4);
               end
            end else if (bus4.out_valid) begin
               chk("w4_S_hold", 32'(bus4.S), 32'(cur.s));
               chk("w4_NEG_hold", 32'(bus4.NEG), 32'(cur.neg));
            end
            prev = bus4.out_valid;
         end
      end
   end

   // Monitor for the 8-bit instance.
   initial begin
      exp_t cur;
      logic prev;
      prev = 1'b0;
      cur  = '{s: 8'd0, neg: 1'b0};
      forever begin
         @(negedge clk);
         if (rst8) begin
            prev = 1'b0;
         end else begin
            if (bus8.in_valid && bus8.in_ready) acc8.push_back(cyc + 1);
            if (bus8.out_valid && !prev) begin
               if (q8.size() == 0) begin
                  chk("w8_unexpected_result", 32'd1, 32'd0);
               end else begin
                  cur = q8.pop_front();
                  chk("w8_S", 32'(bus8.S), 32'(cur.s));
                  chk("w8_NEG", 32'(bus8.NEG), 32'(cur.neg));
                  if (acc8.size() != 0) chk("w8_latency", 32'(cyc - acc8.pop_front()), 32'd8);
               end
            end else if (bus8.out_valid) begin
               chk("w8_S_hold", 32'(bus8.S), 32'(cur.s));
               chk("w8_NEG_hold", 32'(bus8.NEG), 32'(cur.neg));
            end
            prev = bus8.out_valid;
         end
      end
   end

   // Drive one word and hold it until accepted; returns the accepting edge.
   task automatic send4(input logic [3:0] a, output int acc);
      bit got;
      got = 1'b0;
      acc = -1;
      bus4.A        = a;
      bus4.in_valid = 1'b1;
      q4.push_back(model(4, int'(a)));
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (bus4.in_ready) begin
            got = 1'b1;
            acc = cyc + 1;
         end
      end
      if (!got) chk("w4_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] a);
      bit got;
      got = 1'b0;
      bus8.A        = a;
      bus8.in_valid = 1'b1;
      q8.push_back(model(8, int'(a)));
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         bus8.out_ready = 1'($urandom_range(0, 1));
         if (bus8.in_ready) got = 1'b1;
      end
      if (!got) chk("w8_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
   endtask

   task automatic drain4();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (q4.size() == 0 && !bus4.out_valid) ok = 1'b1;
      end
      if (!ok) chk("w4_drain_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain8();
      bit ok;
      ok = 1'b0;
      bus8.out_ready = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (q8.size() == 0 && !bus8.out_valid) ok = 1'b1;
      end
      if (!ok) chk("w8_drain_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      int prev_acc;
      int perm [256];
      int j;
      int t;
      bit seen_valid;

      dir4 = '{4'b0110, 4'b1010, 4'b1111, 4'b1000, 4'b0000, 4'b0111};
      bus4.in_valid = 1'b0; bus4.A = 4'd0; bus4.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.A = 8'd0; bus8.out_ready = 1'b1;
      rst4 = 1'b1;
      rst8 = 1'b1;

      // Reset state while rst is still high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready4", 32'(bus4.in_ready), 32'd0);
      chk("rst_out_valid4", 32'(bus4.out_valid), 32'd0);
      chk("rst_S4", 32'(bus4.S), 32'd0);
      chk("rst_NEG4", 32'(bus4.NEG), 32'd0);
      chk("rst_in_ready8", 32'(bus8.in_ready), 32'd0);
      chk("rst_out_valid8", 32'(bus8.out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst4 = 1'b0;
      rst8 = 1'b0;
      @(negedge clk);
      chk("idle_in_ready4", 32'(bus4.in_ready), 32'd1);
      chk("idle_in_ready8", 32'(bus8.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Back-to-back words with out_ready held high: one word per WIDTH+2.
      prev_acc = -1;
      for (int i = 0; i < 14; i++) begin
         if (i < 6) send4(dir4[i], acc);
         else       send4(4'($urandom_range(0, 15)), acc);
         if (prev_acc >= 0) chk("w4_period", 32'(acc - prev_acc), 32'd6);
         prev_acc = acc;
      end
      drain4();

      // Output stall with in_valid pulses during SHIFT and DONE.
      bus4.out_ready = 1'b0;
      send4(4'b0110, acc);
      bus4.A        = 4'b1111;
      bus4.in_valid = 1'b1;
      @(negedge clk);
      chk("w4_shift_in_ready", 32'(bus4.in_ready), 32'd0);
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 50 && !seen_valid; i++) begin
         @(negedge clk);
         if (bus4.out_valid) seen_valid = 1'b1;
      end
      if (!seen_valid) chk("w4_valid_timeout", 32'd0, 32'd1);
      bus4.A        = 4'b0101;
      bus4.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("w4_done_in_ready", 32'(bus4.in_ready), 32'd0);
         chk("w4_done_out_valid", 32'(bus4.out_valid), 32'd1);
      end
      bus4.A = 4'b0011;
      q4.push_back(model(4, 3));
      bus4.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("w4_ack_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("w4_ack_in_ready", 32'(bus4.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      @(negedge clk);
      chk("w4_next_accept", 32'(bus4.in_ready), 32'd0);
      drain4();

      // One-cycle reset on the second SHIFT edge discards the word.
      send4(4'b1010, acc);
      @(posedge clk);
      #1;
      rst4 = 1'b1;
      q4.delete();
      acc4.delete();
      @(posedge clk);
      #1;
      rst4 = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("mid_rst_S", 32'(bus4.S), 32'd0);
      chk("mid_rst_NEG", 32'(bus4.NEG), 32'd0);
      chk("mid_rst_in_ready", 32'(bus4.in_ready), 32'd1);
      @(posedge clk);
      #1;
      send4(4'b0011, acc);
      drain4();

      // WIDTH=8: every input once, shuffled, with random output stalls.
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
         j       = int'($urandom_range(0, i));
         t       = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      for (int i = 0; i < 256; i++) send8(8'(perm[i]));
      drain8();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
